// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: lane geometry, drain FSM states and a small
// index-width helper reused by the array, its feeder and the psum collector.
package sa_pkg;

    localparam int PSUM_W     = 32;
    localparam int ARRAY_SIZE = 8;
    localparam int TILE_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Width of a column index, kept at least 1 bit for a single-lane array.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Bundle between the psum collector and its environment: control, the psum row
// stream from the array and the per-column output stream.
interface psum_drain_if #(
    parameter int ARRAY_SIZE = sa_pkg::ARRAY_SIZE,
    parameter int PSUM_W     = sa_pkg::PSUM_W,
    parameter int TILE_W     = sa_pkg::TILE_W
);
    localparam int IDX_W = sa_pkg::idx_w(ARRAY_SIZE);

    logic                         start;
    logic [TILE_W-1:0]            num_tiles;
    logic                         psum_valid;
    logic                         psum_ready;
    logic [ARRAY_SIZE*PSUM_W-1:0] psums;
    logic                         out_valid;
    logic                         out_ready;
    logic [PSUM_W-1:0]            out_data;
    logic [IDX_W-1:0]             out_idx;
    logic                         out_last;
    logic                         busy;
    logic                         done;

    modport slave (
        input  start, num_tiles, psum_valid, psums, out_ready,
        output psum_ready, out_valid, out_data, out_idx, out_last, busy, done
    );

    modport master (
        output start, num_tiles, psum_valid, psums, out_ready,
        input  psum_ready, out_valid, out_data, out_idx, out_last, busy, done
    );

endinterface

// File: rtl/psum_drain.sv
// Accumulates num_tiles psum rows per column, then streams one column per beat.
// Latency: final row accepted -> first beat valid next cycle; 1 beat/cycle drain.
// Backpressure: psum_ready only in ACCUM; out_ready stalls hold out_data/out_idx.
module psum_drain #(
    parameter int ARRAY_SIZE = sa_pkg::ARRAY_SIZE,
    parameter int PSUM_W     = sa_pkg::PSUM_W,
    parameter int TILE_W     = sa_pkg::TILE_W
) (
    input  logic         clk,
    input  logic         rst,
    psum_drain_if.slave  bus
);
    import sa_pkg::*;

    localparam int               IDX_W    = idx_w(ARRAY_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

    state_e                            state_q, state_d;
    logic [TILE_W-1:0]                 tiles_left_q, tiles_left_d;
    logic                              first_q, first_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [PSUM_W-1:0]                 out_data_q, out_data_d;
    logic                              done_q, done_d;
    logic [ARRAY_SIZE-1:0][PSUM_W-1:0] acc_q;
    logic [ARRAY_SIZE-1:0][PSUM_W-1:0] acc_sum;
    logic [IDX_W-1:0]                  idx_inc;
    logic                              psum_hs;
    logic                              out_hs;

    assign psum_hs = (state_q == ACCUM) && bus.psum_valid;
    assign out_hs  = (state_q == DRAIN) && bus.out_ready;
    assign idx_inc = idx_q + IDX_W'(1);

    // First accepted row of a run overwrites, so stale sums from a prior run never leak.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        logic [PSUM_W-1:0] lane_in;
        assign lane_in    = bus.psums[i*PSUM_W +: PSUM_W];
        assign acc_sum[i] = first_q ? lane_in : acc_q[i] + lane_in;
    end

    always_comb begin
        state_d      = state_q;
        tiles_left_d = tiles_left_q;
        first_d      = first_q;
        idx_d        = idx_q;
        out_data_d   = out_data_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && (bus.num_tiles != '0)) begin
                    state_d      = ACCUM;
                    tiles_left_d = bus.num_tiles;
                    first_d      = 1'b1;
                    idx_d        = '0;
                end
            end
            ACCUM: begin
                if (psum_hs) begin
                    tiles_left_d = tiles_left_q - TILE_W'(1);
                    first_d      = 1'b0;
                    if (tiles_left_q == TILE_W'(1)) begin
                        state_d    = DRAIN;
                        idx_d      = '0;
                        out_data_d = acc_sum[0];
                    end
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        idx_d      = '0;
                        out_data_d = '0;
                    end else begin
                        idx_d      = idx_inc;
                        out_data_d = acc_q[idx_inc];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tiles_left_q <= '0;
            first_q      <= 1'b0;
            idx_q        <= '0;
            out_data_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tiles_left_q <= tiles_left_d;
            first_q      <= first_d;
            idx_q        <= idx_d;
            out_data_q   <= out_data_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (psum_hs) begin
            acc_q <= acc_sum;
        end
    end

    assign bus.psum_ready = (state_q == ACCUM);
    assign bus.out_valid  = (state_q == DRAIN);
    assign bus.out_data   = out_data_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_last   = (state_q == DRAIN) && (idx_q == LAST_IDX);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;

endmodule

// File: doc/psum_drain.md
# psum_drain

Output-side collector for the Bit Fusion systolic array. It accepts the array's `ARRAY_SIZE` × 32-bit partial-sum row once per tile and accumulates a programmed number of tiles into per-column registers. It then drains the finished row one column per beat over a valid/ready stream toward the output buffer. It is the consumer for the array's `psums` bus; the array and its input feeder stall on `psum_ready`.

## Interface
- `ARRAY_SIZE`, 8, number of columns (psum lanes)
- `PSUM_W`, 32, width of each psum lane and accumulator
- `TILE_W`, 8, width of the tile-count field
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  one-cycle request to begin a new accumulation; honoured only in IDLE
- `num_tiles`  in  TILE_W  number of psum rows to accumulate; sampled with `start`
- `psum_valid`  in  1  `psums` holds a valid row this cycle
- `psum_ready`  out  1  block accepts a row this cycle
- `psums`  in  ARRAY_SIZE*PSUM_W  packed rows; lane i is bits [i*PSUM_W +: PSUM_W], signed two's complement
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  downstream accepts the beat
- `out_data`  out  PSUM_W  accumulated value of column `out_idx`
- `out_idx`  out  $clog2(ARRAY_SIZE)  column index of the current beat
- `out_last`  out  1  high with the beat for column ARRAY_SIZE-1
- `busy`  out  1  high in ACCUM or DRAIN
- `done`  out  1  one-cycle pulse after the last beat is accepted

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - `start` with `num_tiles` != 0 latches `num_tiles` into the tile counter, clears the beat counter and moves to ACCUM.
  - `start` with `num_tiles` == 0 is ignored; the FSM stays in IDLE.
- ACCUM:
  - `psum_ready` is 1.
  - Each handshake (`psum_valid & psum_ready`) updates every lane.
  - The first accepted row loads `acc[i] = psums[i]`. Later rows apply `acc[i] = acc[i] + psums[i]`, with wrap-around modulo 2^PSUM_W and no saturation.
  - The handshake that brings the accepted count to `num_tiles` moves the FSM to DRAIN.
  - A `psum_valid` with no handshake has no effect.
- DRAIN:
  - `out_valid` is 1 and `out_data` = `acc[out_idx]`, starting at `out_idx` = 0.
  - `out_idx` increments on each `out_valid & out_ready`.
  - `out_data` and `out_idx` are held stable while `out_ready` is 0.
  - The handshake with `out_last` = 1 returns the FSM to IDLE and pulses `done` in the next cycle.
- `start` while `busy` is ignored; `num_tiles` is not re-sampled.
- `psum_ready` is 0 in IDLE and DRAIN. Rows offered in those states are not consumed.
- Accumulators are not cleared on entering IDLE. Only the first-row load defines their next contents.

## Timing
- Reset values: FSM = IDLE; `psum_ready`, `out_valid`, `out_last`, `busy` and `done` = 0; `out_idx` = 0; `out_data` = 0; all accumulators = 0; counters = 0.
- Reset mid-operation (in ACCUM or DRAIN) aborts immediately. The next cycle shows the reset values, and no `done` pulse is issued.
- `start` sampled at edge t gives `busy` = 1 and `psum_ready` = 1 from cycle t+1.
- Final row accepted at edge t gives `psum_ready` = 0 and `out_valid` = 1 with `out_idx` = 0 from cycle t+1. Accumulate-to-output latency is 1 cycle.
- Drain throughput is 1 beat per cycle when `out_ready` is held high. An ARRAY_SIZE-column drain therefore takes exactly ARRAY_SIZE cycles.
- Last beat accepted at edge t gives `done` = 1 and `busy` = 0 in cycle t+1. `start` is accepted from cycle t+1.
- No combinational path from `out_ready` to `psum_ready`. `out_valid` does not depend combinationally on `out_ready`.

## Structure
- Shared package `sa_pkg` holds:
  - the FSM state enum (IDLE, ACCUM, DRAIN);
  - `PSUM_W` and the default `ARRAY_SIZE`, which the array and its input feeder also use.
- Single module with a generate loop over lanes. No sub-module; the per-lane logic is only one adder and one register.
- The `out_data` mux is registered from `acc` and `out_idx`.

## Test plan
- Single tile:
  - Stimulus: `num_tiles` = 1; one row with lane i = i+1.
  - Required response: beats give `out_data` 1..8 with `out_idx` 0..7, `out_last` only at index 7, and `done` one cycle after the last beat.
- Three tiles, signed:
  - Stimulus: rows with every lane = 5, −2 and 0x7FFFFFFF.
  - Required response: every lane outputs 0x80000002 (wrap-around).
- Backpressure:
  - Stimulus: `out_ready` toggles 1,0,0,1,…
  - Required response: `out_data` and `out_idx` are stable while stalled, no beat is skipped or duplicated, and 8 beats are accepted in total.
- Gaps and ignored inputs:
  - Stimulus: `psum_valid` gaps in ACCUM; rows offered during DRAIN; `start` while busy; `num_tiles` = 0.
  - Required response: only handshaken rows count, state is unchanged by the ignored inputs, and `num_tiles` = 0 leaves the FSM in IDLE.
- Reset mid-DRAIN:
  - Stimulus: assert `rst` at `out_idx` = 3.
  - Required response: all outputs at reset values next cycle, no `done` pulse, and a fresh 1-tile run afterwards produces correct values.
- Back-to-back runs:
  - Stimulus: `start` asserted in the cycle `done` is high.
  - Required response: the second run loads fresh rows with no leftover contribution from the first run.
